// File: rtl/vecmax_seq_if.sv
// fixedp: clock/reset bundle for the fixed-point datapath, also carrying the
// element width used by attached blocks.
//   clk    - rising-edge clock
//   reset  - synchronous, active-high reset
//   WIDTH  - element width in bits (parameter)
interface fixedp #(
    parameter int unsigned WIDTH = 16
);
    logic clk;
    logic reset;

    // Driver side (clock/reset generator)
    modport master (output clk, output reset);
    // Consumer side (datapath blocks)
    modport slave  (input clk, input reset);
endinterface

// File: rtl/vecmax_seq.sv
// vecmax_seq: sequential signed max/argmax over elements 1..COLS of a vector
// read through an arbitrated, 1-cycle-latency memory port.
// Ports:
//   g        - fixedp bundle (clk, reset, WIDTH)
//   start    - begin a scan (sampled only when idle)
//   busy     - scan in progress
//   rd_en    - read request to the arbiter
//   rd_addr  - 1-based element address
//   rd_gnt   - grant for the current request
//   rd_data  - signed element, valid the cycle after a granted request
//   f        - signed maximum of the last completed scan
//   idx      - 1-based index of f (lowest index on ties)
//   done     - one-cycle completion pulse
module vecmax_seq #(
    parameter int unsigned COLS  = 1,
    parameter int unsigned ADDRW = $clog2(COLS + 1)
) (
    fixedp.slave                      g,
    input  logic                      start,
    output logic                      busy,
    output logic                      rd_en,
    output logic [ADDRW-1:0]          rd_addr,
    input  logic                      rd_gnt,
    input  logic signed [g.WIDTH-1:0] rd_data,
    output logic signed [g.WIDTH-1:0] f,
    output logic [ADDRW-1:0]          idx,
    output logic                      done
);

    localparam int unsigned W = g.WIDTH;
    localparam logic [ADDRW-1:0] ADDR_FIRST = ADDRW'(1);
    localparam logic [ADDRW-1:0] ADDR_LAST  = ADDRW'(COLS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t state_q, state_n;

    // Next values for the registered outputs and control flags
    logic                  busy_n, rd_en_n, done_n;
    logic [ADDRW-1:0]      addr_n;
    logic                  pend_n;
    logic                  scan_begin;
    logic                  load_result;

    // Response tracking and running maximum
    logic                  pend_q;
    logic [ADDRW-1:0]      pend_addr_q;
    logic                  first_q;
    logic signed [W-1:0]   max_q;
    logic [ADDRW-1:0]      max_idx_q;

    // State register
    always_ff @(posedge g.clk) begin
        if (g.reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE:  if (start) state_n = S_READ;
            S_READ:  if (rd_gnt && (rd_addr == ADDR_LAST)) state_n = S_DRAIN;
            S_DRAIN: state_n = S_FIN;
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Output / datapath-control logic (feeds the output registers)
    always_comb begin
        busy_n      = (state_n != S_IDLE);
        rd_en_n     = (state_n == S_READ);
        done_n      = (state_q == S_FIN);
        addr_n      = rd_addr;
        pend_n      = 1'b0;
        scan_begin  = 1'b0;
        load_result = (state_q == S_FIN);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_n     = ADDR_FIRST;
                    scan_begin = 1'b1;
                end
            end
            S_READ: begin
                // Address holds while the grant is withheld
                if (rd_gnt) begin
                    pend_n = 1'b1;
                    if (rd_addr != ADDR_LAST) addr_n = rd_addr + ADDRW'(1);
                end
            end
            default: ;
        endcase
    end

    // Registered outputs, response capture and running maximum
    always_ff @(posedge g.clk) begin
        if (g.reset) begin
            busy        <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= ADDR_FIRST;
            done        <= 1'b0;
            f           <= '0;
            idx         <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            first_q     <= 1'b1;
            max_q       <= '0;
            max_idx_q   <= '0;
        end else begin
            busy        <= busy_n;
            rd_en       <= rd_en_n;
            rd_addr     <= addr_n;
            done        <= done_n;
            pend_q      <= pend_n;
            pend_addr_q <= rd_addr;

            if (scan_begin) first_q <= 1'b1;

            // First element loads unconditionally; later ones only if strictly greater
            if (pend_q) begin
                first_q <= 1'b0;
                if (first_q || (rd_data > max_q)) begin
                    max_q     <= rd_data;
                    max_idx_q <= pend_addr_q;
                end
            end

            if (load_result) begin
                f   <= max_q;
                idx <= max_idx_q;
            end
        end
    end

endmodule

// File: tb/tb_vecmax_seq.sv
module tb_vecmax_seq;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    // COLS=4 instance
    logic        start4, gnt4, busy4, rd_en4, done4;
    logic [2:0]  rd_addr4, idx4;
    logic [15:0] rdata4, f4;
    logic [15:0] mem4 [4];
    int          done_cnt4 = 0;

    // COLS=1 instance
    logic        start1, gnt1, busy1, rd_en1, done1;
    logic [0:0]  rd_addr1, idx1;
    logic [15:0] rdata1, f1;
    logic [15:0] mem1;
    int          gnt_cnt1 = 0;

    fixedp #(.WIDTH(16)) g4 ();
    fixedp #(.WIDTH(16)) g1 ();
    assign g4.clk   = clk;
    assign g4.reset = rst;
    assign g1.clk   = clk;
    assign g1.reset = rst;

    vecmax_seq #(.COLS(4)) dut4 (
        .g(g4), .start(start4), .busy(busy4), .rd_en(rd_en4), .rd_addr(rd_addr4),
        .rd_gnt(gnt4), .rd_data(rdata4), .f(f4), .idx(idx4), .done(done4)
    );

    vecmax_seq #(.COLS(1)) dut1 (
        .g(g1), .start(start1), .busy(busy1), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .rd_gnt(gnt1), .rd_data(rdata1), .f(f1), .idx(idx1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: data one cycle after a grant, junk otherwise
    always @(posedge clk) begin
        if (rd_en4 && gnt4) rdata4 <= mem4[int'(rd_addr4) - 1];
        else                rdata4 <= 16'h7FFF;
        if (rd_en1 && gnt1) rdata1 <= mem1;
        else                rdata1 <= 16'h7FFF;
        if (done4) done_cnt4 <= done_cnt4 + 1;
        if (rd_en1 && gnt1) gnt_cnt1 <= gnt_cnt1 + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load4(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
        mem4[0] = a; mem4[1] = b; mem4[2] = c; mem4[3] = d;
    endtask

    // Advance until done4 is seen; returns edges since E0 (capped at 50)
    task automatic wait_done4(input int n_in, output int n_out);
        int n = n_in;
        while (done4 !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        n_out = n;
    endtask

    task automatic wait_done1(input int n_in, output int n_out);
        int n = n_in;
        while (done1 !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        n_out = n;
    endtask

    task automatic test_reset;
        rst = 1'b1; start4 = 1'b0; start1 = 1'b0; gnt4 = 1'b1; gnt1 = 1'b1;
        repeat (3) tick();
        n_checks++; if (busy4 !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy4); end
        n_checks++; if (rd_en4 !== 1'b0)    begin n_fail++; $display("FAIL reset_rd_en got %0b want 0", rd_en4); end
        n_checks++; if (rd_addr4 !== 3'd1)  begin n_fail++; $display("FAIL reset_rd_addr got %0d want 1", rd_addr4); end
        n_checks++; if (f4 !== 16'h0000)    begin n_fail++; $display("FAIL reset_f got %h want 0000", f4); end
        n_checks++; if (idx4 !== 3'd0)      begin n_fail++; $display("FAIL reset_idx got %0d want 0", idx4); end
        n_checks++; if (done4 !== 1'b0)     begin n_fail++; $display("FAIL reset_done got %0b want 0", done4); end
        n_checks++; if (rd_addr1 !== 1'b1)  begin n_fail++; $display("FAIL reset_rd_addr_c1 got %0d want 1", rd_addr1); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        int n;
        load4(16'hFFFD, 16'd7, 16'd7, 16'hFF9C);
        gnt4 = 1'b1;
        start4 = 1'b1;
        tick();  // E0
        start4 = 1'b0;
        n_checks++; if (busy4 !== 1'b1)    begin n_fail++; $display("FAIL basic_busy got %0b want 1", busy4); end
        n_checks++; if (rd_en4 !== 1'b1)   begin n_fail++; $display("FAIL basic_rd_en got %0b want 1", rd_en4); end
        n_checks++; if (rd_addr4 !== 3'd1) begin n_fail++; $display("FAIL basic_addr1 got %0d want 1", rd_addr4); end
        for (int k = 2; k <= 4; k++) begin
            tick();
            n_checks++; if (rd_addr4 !== 3'(k)) begin n_fail++; $display("FAIL basic_addr_step got %0d want %0d", rd_addr4, k); end
            n_checks++; if (f4 !== 16'h0000)    begin n_fail++; $display("FAIL basic_f_hold got %h want 0000", f4); end
        end
        tick();  // E4
        n_checks++; if (rd_en4 !== 1'b0) begin n_fail++; $display("FAIL basic_drain_rd_en got %0b want 0", rd_en4); end
        wait_done4(4, n);
        n_checks++; if (n !== 6)          begin n_fail++; $display("FAIL basic_latency got %0d want 6", n); end
        n_checks++; if (f4 !== 16'd7)     begin n_fail++; $display("FAIL basic_f got %h want 0007", f4); end
        n_checks++; if (idx4 !== 3'd2)    begin n_fail++; $display("FAIL basic_idx got %0d want 2", idx4); end
        n_checks++; if (busy4 !== 1'b0)   begin n_fail++; $display("FAIL basic_busy_done got %0b want 0", busy4); end
        tick();
        n_checks++; if (done4 !== 1'b0)   begin n_fail++; $display("FAIL basic_done_pulse got %0b want 0", done4); end
        n_checks++; if (f4 !== 16'd7)     begin n_fail++; $display("FAIL basic_f_hold_after got %h want 0007", f4); end
    endtask

    task automatic test_signed;
        int n;
        load4(16'hFFFB, 16'hFFFE, 16'hFFF7, 16'hFFFE);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        wait_done4(0, n);
        n_checks++; if (n !== 6)          begin n_fail++; $display("FAIL signed_latency got %0d want 6", n); end
        n_checks++; if (f4 !== 16'hFFFE)  begin n_fail++; $display("FAIL signed_f got %h want fffe", f4); end
        n_checks++; if (idx4 !== 3'd2)    begin n_fail++; $display("FAIL signed_idx got %0d want 2", idx4); end
        tick();
    endtask

    task automatic test_stall;
        int n;
        load4(16'hFFFD, 16'd7, 16'd7, 16'hFF9C);
        start4 = 1'b1;
        tick();  // E0
        start4 = 1'b0;
        tick();  // E1
        tick();  // E2
        n_checks++; if (rd_addr4 !== 3'd3) begin n_fail++; $display("FAIL stall_pre_addr got %0d want 3", rd_addr4); end
        gnt4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (rd_addr4 !== 3'd3) begin n_fail++; $display("FAIL stall_addr_hold got %0d want 3", rd_addr4); end
            n_checks++; if (rd_en4 !== 1'b1)   begin n_fail++; $display("FAIL stall_rd_en got %0b want 1", rd_en4); end
        end
        gnt4 = 1'b1;
        wait_done4(5, n);
        n_checks++; if (n !== 9)          begin n_fail++; $display("FAIL stall_latency got %0d want 9", n); end
        n_checks++; if (f4 !== 16'd7)     begin n_fail++; $display("FAIL stall_f got %h want 0007", f4); end
        n_checks++; if (idx4 !== 3'd2)    begin n_fail++; $display("FAIL stall_idx got %0d want 2", idx4); end
        tick();
    endtask

    task automatic test_start_while_busy;
        int n;
        int c0;
        load4(16'd10, 16'hFFFF, 16'd20, 16'd5);
        c0 = done_cnt4;
        start4 = 1'b1;
        tick();  // E0
        start4 = 1'b0;
        tick();  // E1
        start4 = 1'b1;
        tick();  // E2
        start4 = 1'b0;
        n_checks++; if (rd_addr4 !== 3'd3) begin n_fail++; $display("FAIL busy_start_addr got %0d want 3", rd_addr4); end
        wait_done4(2, n);
        n_checks++; if (n !== 6)          begin n_fail++; $display("FAIL busy_start_latency got %0d want 6", n); end
        n_checks++; if (f4 !== 16'd20)    begin n_fail++; $display("FAIL busy_start_f got %h want 0014", f4); end
        n_checks++; if (idx4 !== 3'd3)    begin n_fail++; $display("FAIL busy_start_idx got %0d want 3", idx4); end
        repeat (10) tick();
        n_checks++; if (done_cnt4 - c0 !== 1) begin n_fail++; $display("FAIL busy_start_pulses got %0d want 1", done_cnt4 - c0); end
    endtask

    task automatic test_reset_mid;
        int n;
        int c0;
        load4(16'd1, 16'd2, 16'd3, 16'd4);
        c0 = done_cnt4;
        start4 = 1'b1;
        tick();  // E0
        start4 = 1'b0;
        tick();  // E1
        n_checks++; if (rd_addr4 !== 3'd2) begin n_fail++; $display("FAIL rstmid_pre_addr got %0d want 2", rd_addr4); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (f4 !== 16'h0000)   begin n_fail++; $display("FAIL rstmid_f got %h want 0000", f4); end
        n_checks++; if (idx4 !== 3'd0)     begin n_fail++; $display("FAIL rstmid_idx got %0d want 0", idx4); end
        n_checks++; if (busy4 !== 1'b0)    begin n_fail++; $display("FAIL rstmid_busy got %0b want 0", busy4); end
        n_checks++; if (rd_en4 !== 1'b0)   begin n_fail++; $display("FAIL rstmid_rd_en got %0b want 0", rd_en4); end
        n_checks++; if (rd_addr4 !== 3'd1) begin n_fail++; $display("FAIL rstmid_addr got %0d want 1", rd_addr4); end
        repeat (10) tick();
        n_checks++; if (done_cnt4 !== c0)  begin n_fail++; $display("FAIL rstmid_no_done got %0d want %0d", done_cnt4, c0); end
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        wait_done4(0, n);
        n_checks++; if (n !== 6)          begin n_fail++; $display("FAIL rstmid_latency got %0d want 6", n); end
        n_checks++; if (f4 !== 16'd4)     begin n_fail++; $display("FAIL rstmid_new_f got %h want 0004", f4); end
        n_checks++; if (idx4 !== 3'd4)    begin n_fail++; $display("FAIL rstmid_new_idx got %0d want 4", idx4); end
        tick();
    endtask

    task automatic test_cols1;
        int n;
        int g0;
        mem1 = 16'h8000;
        gnt1 = 1'b1;
        g0 = gnt_cnt1;
        start1 = 1'b1;
        tick();  // E0
        start1 = 1'b0;
        n_checks++; if (rd_en1 !== 1'b1)   begin n_fail++; $display("FAIL c1_rd_en got %0b want 1", rd_en1); end
        n_checks++; if (rd_addr1 !== 1'b1) begin n_fail++; $display("FAIL c1_addr got %0d want 1", rd_addr1); end
        wait_done1(0, n);
        n_checks++; if (n !== 3)          begin n_fail++; $display("FAIL c1_latency got %0d want 3", n); end
        n_checks++; if (f1 !== 16'h8000)  begin n_fail++; $display("FAIL c1_f got %h want 8000", f1); end
        n_checks++; if (idx1 !== 1'b1)    begin n_fail++; $display("FAIL c1_idx got %0d want 1", idx1); end
        n_checks++; if (gnt_cnt1 - g0 !== 1) begin n_fail++; $display("FAIL c1_requests got %0d want 1", gnt_cnt1 - g0); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_stall();
        test_start_while_busy();
        test_reset_mid();
        test_cols1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
